pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_if.sv | 29 ++
 rtl/pc_sequencer.sv | 80 ++++++++
 tb/tb_pc_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Bus bundle for pc_sequencer: control inputs from the pipeline and fetch-side outputs.
// slave = the sequencer itself, master = whatever drives the pipeline controls.
interface pc_sequencer_if;
  logic        stall;
  logic        imem_ack;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_req;
  logic        flush;
  logic        misalign_err;
  logic [7:0]  redirect_count;
  logic [1:0]  state_dbg;

  modport slave (
    input  stall, imem_ack, branch_taken, branch_offset, jump, jump_index, jr, jr_addr,
    output pc, pc_plus4, fetch_req, flush, misalign_err, redirect_count, state_dbg
  );

  modport master (
    output stall, imem_ack, branch_taken, branch_offset, jump, jump_index, jr, jr_addr,
    input  pc, pc_plus4, fetch_req, flush, misalign_err, redirect_count, state_dbg
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/FETCH/ERROR FSM with jr > jump > branch > sequential
// next-PC selection, one-cycle flush after a redirect and a saturating redirect counter.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  pc_sequencer_if.slave   bus
);
  // Handshake: a fetch completes on an edge where fetch_req & imem_ack & ~stall; an
  // acknowledge that coincides with stall is dropped and the same pc is fetched again.
  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ERROR = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] branch_tgt;
  logic [31:0] next_pc;
  logic        flush_q;
  logic        err_q;
  logic [7:0]  cnt_q;
  logic        advance;
  logic        redirect;
  logic        misalign;

  assign pc_plus4   = pc_q + 32'd4;
  assign branch_tgt = pc_plus4 + {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
  assign advance    = (state == FETCH) & bus.imem_ack & ~bus.stall;
  assign redirect   = bus.jr | bus.jump | bus.branch_taken;
  // Only a register jump can carry a misaligned target.
  assign misalign   = bus.jr & (bus.jr_addr[1:0] != 2'b00);

  always_comb begin
    next_pc = pc_plus4;
    if (bus.jr)                next_pc = bus.jr_addr;
    else if (bus.jump)         next_pc = {pc_plus4[31:28], bus.jump_index, 2'b00};
    else if (bus.branch_taken) next_pc = branch_tgt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= BOOT;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      flush_q <= 1'b0;
      case (state)
        BOOT:  state <= FETCH;
        FETCH: begin
          if (advance) begin
            if (misalign) begin
              err_q <= 1'b1;
              state <= ERROR;
            end else begin
              pc_q <= next_pc;
              if (redirect) begin
                flush_q <= 1'b1;
                if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
              end
            end
          end
        end
        ERROR:   state <= ERROR;
        default: state <= BOOT;
      endcase
    end
  end

  assign bus.pc             = pc_q;
  assign bus.pc_plus4       = pc_plus4;
  assign bus.fetch_req      = (state == FETCH);
  assign bus.flush          = flush_q;
  assign bus.misalign_err   = err_q;
  assign bus.redirect_count = cnt_q;
  assign bus.state_dbg      = state;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written corner
// sequences and randomized traffic compared against a behavioural PC model.
module tb_pc_sequencer;
  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        ack;
    logic        bt;
    logic [15:0] off;
    logic        jump;
    logic [25:0] ji;
    logic        jr;
    logic [31:0] ja;
  } stim_t;

  typedef struct {
    string       name;
    stim_t       in;
    logic [31:0] pc;
    logic        fr;
    logic        fl;
    logic        er;
    logic [7:0]  cnt;
  } vec_t;

  localparam int W = 75;

  logic clk = 1'b0;
  logic reset;
  pc_sequencer_if bus();

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // behavioural model
  logic [31:0] m_pc;
  bit          m_booted, m_halted, m_flush, m_err;
  int          m_cnt;

  function automatic stim_t mk(input logic rst, stall, ack, bt, input logic [15:0] off,
                               input logic jump, input logic [25:0] ji,
                               input logic jr, input logic [31:0] ja);
    stim_t s;
    s.rst = rst; s.stall = stall; s.ack = ack; s.bt = bt; s.off = off;
    s.jump = jump; s.ji = ji; s.jr = jr; s.ja = ja;
    return s;
  endfunction

  task automatic model_step(input stim_t s);
    logic [31:0] seq, tgt;
    if (s.rst) begin
      m_pc = 32'h0; m_booted = 0; m_halted = 0; m_flush = 0; m_err = 0; m_cnt = 0;
    end else if (!m_booted) begin
      m_booted = 1; m_flush = 0;
    end else if (m_halted) begin
      m_flush = 0;
    end else begin
      m_flush = 0;
      if (s.ack && !s.stall) begin
        if (s.jr && (s.ja % 4 != 0)) begin
          m_halted = 1; m_err = 1;
        end else begin
          seq = m_pc + 32'd4;
          if (s.jr)        tgt = s.ja;
          else if (s.jump) tgt = (seq & 32'hF000_0000) | (32'(s.ji) * 32'd4);
          else if (s.bt)   tgt = seq + 32'(int'($signed(s.off)) * 4);
          else             tgt = seq;
          m_pc = tgt;
          if (s.jr || s.jump || s.bt) begin
            m_flush = 1;
            if (m_cnt < 255) m_cnt++;
          end
        end
      end
    end
  endtask

  // driver: present inputs, take one edge, sample 1 time unit later
  task automatic apply(input stim_t s);
    reset             = s.rst;
    bus.stall         = s.stall;
    bus.imem_ack      = s.ack;
    bus.branch_taken  = s.bt;
    bus.branch_offset = s.off;
    bus.jump          = s.jump;
    bus.jump_index    = s.ji;
    bus.jr            = s.jr;
    bus.jr_addr       = s.ja;
    @(posedge clk);
    #1;
    model_step(s);
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] e_pc, input logic e_fr,
                       input logic e_fl, input logic e_er, input logic [7:0] e_cnt);
    logic [W-1:0] act, exp;
    exp_q.push_back({e_pc, e_pc + 32'd4, e_fr, e_fl, e_er, e_cnt});
    act = {bus.pc, bus.pc_plus4, bus.fetch_req, bus.flush, bus.misalign_err, bus.redirect_count};
    exp = exp_q.pop_front();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got pc=%h pc4=%h fetch_req=%b flush=%b err=%b cnt=%h, expected pc=%h pc4=%h fetch_req=%b flush=%b err=%b cnt=%h",
               name, act[74:43], act[42:11], act[10], act[9], act[8], act[7:0],
               exp[74:43], exp[42:11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_pc, m_booted && !m_halted, m_flush, m_err, 8'(m_cnt));
  endtask

  vec_t  tbl[16];
  stim_t idle, rst_s, ack_s, rs;

  initial begin
    idle  = mk(0,0,0,0,16'h0,0,26'h0,0,32'h0);
    rst_s = mk(1,0,0,0,16'h0,0,26'h0,0,32'h0);
    ack_s = mk(0,0,1,0,16'h0,0,26'h0,0,32'h0);

    tbl[0]  = '{"boot_ack",      ack_s,                                         32'h0,         1,0,0,8'd0};
    tbl[1]  = '{"seq_4",         ack_s,                                         32'h4,         1,0,0,8'd0};
    tbl[2]  = '{"seq_8",         ack_s,                                         32'h8,         1,0,0,8'd0};
    tbl[3]  = '{"branch_back",   mk(0,0,1,1,16'hFFFE,0,26'h0,0,32'h0),          32'h4,         1,1,0,8'd1};
    tbl[4]  = '{"no_ack_hold",   idle,                                          32'h4,         1,0,0,8'd1};
    tbl[5]  = '{"priority_jr",   mk(0,0,1,1,16'h0,1,26'h40,1,32'h100),          32'h100,       1,1,0,8'd2};
    tbl[6]  = '{"jump",          mk(0,0,1,0,16'h0,1,26'h123,0,32'h0),           32'h48C,       1,1,0,8'd3};
    tbl[7]  = '{"seq_after_jmp", ack_s,                                         32'h490,       1,0,0,8'd3};
    tbl[8]  = '{"seq_494",       ack_s,                                         32'h494,       1,0,0,8'd3};
    tbl[9]  = '{"stall_ack",     mk(1'b0,1,1,1,16'h5,0,26'h0,0,32'h0),          32'h494,       1,0,0,8'd3};
    tbl[10] = '{"stall_release", mk(0,0,1,1,16'h5,0,26'h0,0,32'h0),             32'h4AC,       1,1,0,8'd4};
    tbl[11] = '{"jump_max_idx",  mk(0,0,1,0,16'h0,1,26'h3FF_FFFF,0,32'h0),      32'h0FFF_FFFC, 1,1,0,8'd5};
    tbl[12] = '{"ignore_no_ack", mk(0,0,0,1,16'h0,0,26'h0,1,32'h102),           32'h0FFF_FFFC, 1,0,0,8'd5};
    tbl[13] = '{"branch_pos",    mk(0,0,1,1,16'h7FFF,0,26'h0,0,32'h0),          32'h1001_FFFC, 1,1,0,8'd6};
    tbl[14] = '{"jump_region",   mk(0,0,1,0,16'h0,1,26'h1,0,32'h0),             32'h1000_0004, 1,1,0,8'd7};
    tbl[15] = '{"seq_region",    ack_s,                                         32'h1000_0008, 1,0,0,8'd7};

    apply(rst_s);
    check("reset_state", 32'h0, 0, 0, 0, 8'd0);
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].in);
      check(tbl[i].name, tbl[i].pc, tbl[i].fr, tbl[i].fl, tbl[i].er, tbl[i].cnt);
    end

    // misaligned register jump, frozen ERROR state, reset exit
    apply(rst_s);
    apply(idle);
    apply(ack_s);
    check("pre_misalign", 32'h4, 1, 0, 0, 8'd0);
    apply(mk(0,0,1,0,16'h0,0,26'h0,1,32'h102));
    check("misalign", 32'h4, 0, 0, 1, 8'd0);
    apply(mk(0,0,1,1,16'h3,1,26'h5,1,32'h200));
    check("error_frozen", 32'h4, 0, 0, 1, 8'd0);
    apply(mk(1,0,1,0,16'h0,0,26'h0,1,32'h200));
    check("error_reset", 32'h0, 0, 0, 0, 8'd0);

    // 32-bit wrap in both directions
    apply(idle);
    apply(mk(0,0,1,0,16'h0,0,26'h0,1,32'hFFFF_FFFC));
    check("jr_top", 32'hFFFF_FFFC, 1, 1, 0, 8'd1);
    apply(ack_s);
    check("wrap_seq", 32'h0, 1, 0, 0, 8'd1);
    apply(mk(0,0,1,1,16'hFFFE,0,26'h0,0,32'h0));
    check("wrap_neg", 32'hFFFF_FFFC, 1, 1, 0, 8'd2);

    // reset beats a redirect and clears the pending flush
    apply(mk(1,0,1,1,16'h4,0,26'h0,0,32'h0));
    check("reset_redirect", 32'h0, 0, 0, 0, 8'd0);

    // counter saturation over 300 redirects
    apply(idle);
    for (int i = 0; i < 300; i++) begin
      apply(mk(0,0,1,1,16'h0,0,26'h0,0,32'h0));
      if (i == 253) check("sat_254", 32'h3F8, 1, 1, 0, 8'hFE);
      if (i == 254) check("sat_255", 32'h3FC, 1, 1, 0, 8'hFF);
      if (i == 255) check("sat_256", 32'h400, 1, 1, 0, 8'hFF);
    end
    check("sat_300", 32'h4B0, 1, 1, 0, 8'hFF);

    // randomized traffic against the model
    apply(rst_s);
    for (int i = 0; i < 2000; i++) begin
      rs.rst   = ($urandom_range(0, 63) == 0);
      rs.stall = ($urandom_range(0, 3) == 0);
      rs.ack   = ($urandom_range(0, 3) != 0);
      rs.bt    = ($urandom_range(0, 3) == 0);
      rs.off   = 16'($urandom);
      rs.jump  = ($urandom_range(0, 7) == 0);
      rs.ji    = 26'($urandom);
      rs.jr    = ($urandom_range(0, 7) == 0);
      rs.ja    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(0, 15) == 0) rs.ja[1:0] = 2'($urandom_range(1, 3));
      apply(rs);
      check_model("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
